decode_operand_fetch: RTL and testbench

- Second stage of the 3-stage pipeline. Decodes the 16-bit instruction from fetch and reads operands from an internal 16x16 register file.
- Registers opcode, destReg, operand values, memAddr and forwarding flags (used1/used2) into the execute/store-back stage.
- Owns load-use stall generation and halt sequencing.
- Register file write port is driven by the writeback path (execute result or load data).

---
 rtl/decode_operand_fetch_pkg.sv | 78 +++++++
 rtl/decode_operand_fetch_if.sv | 38 +++
 rtl/decode_operand_fetch_reg_file.sv | 49 ++++
 rtl/decode_operand_fetch.sv | 175 +++++++++++++++++
 tb/tb_decode_operand_fetch.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_operand_fetch_pkg
//  Description : Shared opcode map, instruction field positions, FSM state
//                encoding and opcode classification helpers for the
//                decode / operand-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_operand_fetch_pkg;

    localparam int NUM_REGS   = 16;
    localparam int DATA_W     = 16;
    localparam int REG_IDX_W  = 4;
    localparam int OPC_W      = 4;
    localparam int MEM_ADDR_W = 8;

    // Instruction field positions
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int DST_MSB  = 11;
    localparam int DST_LSB  = 8;
    localparam int SRC1_MSB = 7;
    localparam int SRC1_LSB = 4;
    localparam int SRC2_MSB = 3;
    localparam int SRC2_LSB = 0;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 4'd0,
        OP_HLT   = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_CMP   = 4'd8,
        OP_NOT   = 4'd9,
        OP_XOR   = 4'd10,
        OP_RSV11 = 4'd11,
        OP_RSV12 = 4'd12,
        OP_RSV13 = 4'd13,
        OP_LOAD  = 4'd14,
        OP_STORE = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // ALU class: opcodes ADD..XOR
    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    // Opcodes 11..13 have no meaning and are issued as NOP
    function automatic logic is_defined(input logic [OPC_W-1:0] op);
        return (op < OP_RSV11) || (op > OP_RSV13);
    endfunction

    function automatic logic is_writer(input logic [OPC_W-1:0] op);
        return is_alu(op) || (op == OP_LOAD);
    endfunction

    function automatic logic uses_src1(input logic [OPC_W-1:0] op);
        return is_alu(op) || (op == OP_STORE);
    endfunction

    // NOT is unary, so it never reads its second operand
    function automatic logic uses_src2(input logic [OPC_W-1:0] op);
        return is_alu(op) && (op != OP_NOT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_operand_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_operand_fetch_if
//  Description : Bus between fetch / writeback (master side) and the decode /
//                operand-fetch stage (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_operand_fetch_if;
    import decode_operand_fetch_pkg::*;

    logic [DATA_W-1:0]     instr;
    logic                  instrValid;
    logic                  stall;
    logic                  wbEn;
    logic [REG_IDX_W-1:0]  wbReg;
    logic [DATA_W-1:0]     wbVal;
    logic [OPC_W-1:0]      opcode;
    logic [REG_IDX_W-1:0]  destReg;
    logic [DATA_W-1:0]     srcVal1;
    logic [DATA_W-1:0]     srcVal2;
    logic [MEM_ADDR_W-1:0] memAddr;
    logic                  used1;
    logic                  used2;
    logic                  halted;

    modport master (
        output instr, instrValid, wbEn, wbReg, wbVal,
        input  stall, opcode, destReg, srcVal1, srcVal2, memAddr,
               used1, used2, halted
    );

    modport slave (
        input  instr, instrValid, wbEn, wbReg, wbVal,
        output stall, opcode, destReg, srcVal1, srcVal2, memAddr,
               used1, used2, halted
    );
endinterface
`default_nettype wire

// File: rtl/decode_operand_fetch_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_16x16
//  Description : 16 x 16-bit register file. Two combinational read ports with
//                same-cycle write bypass, one write port, async reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_16x16
    import decode_operand_fetch_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_we,
    input  wire logic [REG_IDX_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0]    i_wdata,
    input  wire logic [REG_IDX_W-1:0] i_raddr1,
    input  wire logic [REG_IDX_W-1:0] i_raddr2,
    output logic      [DATA_W-1:0]    o_rdata1,
    output logic      [DATA_W-1:0]    o_rdata2
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Next register contents: only the addressed entry changes on a write
    always_comb begin
        regs_d = regs_q;
        if (i_we) begin
            regs_d[i_waddr] = i_wdata;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        // Storage element for one register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs_q[gi] <= '0;
            end else begin
                regs_q[gi] <= regs_d[gi];
            end
        end
    end

    // A value being written this cycle is visible to readers immediately
    assign o_rdata1 = (i_we && (i_waddr == i_raddr1)) ? i_wdata : regs_q[i_raddr1];
    assign o_rdata2 = (i_we && (i_waddr == i_raddr2)) ? i_wdata : regs_q[i_raddr2];

endmodule
`default_nettype wire

// File: rtl/decode_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : decode_operand_fetch
//  Description : Pipeline stage 2. Decodes the fetched instruction, reads its
//                operands, flags forwarding from the previous ALU result,
//                inserts one bubble on a load-use hazard and parks in HALT
//                after issuing HLT.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_operand_fetch
    import decode_operand_fetch_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst,
    decode_operand_fetch_if.slave bus
);

    state_t                state_q,  state_d;
    logic [DATA_W-1:0]     held_q,   held_d;
    logic [OPC_W-1:0]      opcode_q, opcode_d;
    logic [REG_IDX_W-1:0]  dest_q,   dest_d;
    logic [DATA_W-1:0]     src1_q,   src1_d;
    logic [DATA_W-1:0]     src2_q,   src2_d;
    logic [MEM_ADDR_W-1:0] mem_q,    mem_d;
    logic                  used1_q,  used1_d;
    logic                  used2_q,  used2_d;

    logic [DATA_W-1:0]     w_cur_instr;
    logic [OPC_W-1:0]      w_op_raw;
    logic [REG_IDX_W-1:0]  w_idx1;
    logic [REG_IDX_W-1:0]  w_idx2;
    logic [DATA_W-1:0]     w_rd1;
    logic [DATA_W-1:0]     w_rd2;
    logic                  w_use1;
    logic                  w_use2;
    logic                  w_hazard;
    logic                  w_stall;
    logic                  w_issue;
    logic [OPC_W-1:0]      w_dec_op;
    logic [REG_IDX_W-1:0]  w_dec_dest;
    logic [MEM_ADDR_W-1:0] w_dec_mem;
    logic [DATA_W-1:0]     w_dec_src1;
    logic [DATA_W-1:0]     w_dec_src2;
    logic                  w_dec_used1;
    logic                  w_dec_used2;

    // In STALL the instruction captured at the hazard is the one being issued
    assign w_cur_instr = (state_q == ST_STALL) ? held_q : bus.instr;
    assign w_op_raw    = w_cur_instr[OPC_MSB:OPC_LSB];

    // STORE carries its data register in the destination field
    assign w_idx1 = (w_op_raw == OP_STORE) ? w_cur_instr[DST_MSB:DST_LSB]
                                           : w_cur_instr[SRC1_MSB:SRC1_LSB];
    assign w_idx2 = w_cur_instr[SRC2_MSB:SRC2_LSB];
    assign w_use1 = uses_src1(w_op_raw);
    assign w_use2 = uses_src2(w_op_raw);

    // The registered issue slot is the previously issued instruction
    assign w_hazard = (opcode_q == OP_LOAD) &&
                      ((w_use1 && (w_idx1 == dest_q)) ||
                       (w_use2 && (w_idx2 == dest_q)));

    reg_file_16x16 u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .i_we     (bus.wbEn),
        .i_waddr  (bus.wbReg),
        .i_wdata  (bus.wbVal),
        .i_raddr1 (w_idx1),
        .i_raddr2 (w_idx2),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    // Decode the current instruction into the fields it would issue with
    always_comb begin
        w_dec_op    = is_defined(w_op_raw) ? w_op_raw : OP_NOP;
        w_dec_dest  = is_writer(w_dec_op) ? w_cur_instr[DST_MSB:DST_LSB] : '0;
        w_dec_mem   = ((w_dec_op == OP_LOAD) || (w_dec_op == OP_STORE))
                      ? w_cur_instr[ADDR_MSB:ADDR_LSB] : '0;
        w_dec_src1  = w_use1 ? w_rd1 : '0;
        w_dec_src2  = w_use2 ? w_rd2 : '0;
        w_dec_used1 = w_use1 && is_alu(opcode_q) && (w_idx1 == dest_q);
        w_dec_used2 = w_use2 && is_alu(opcode_q) && (w_idx2 == dest_q);
    end

    // Next state and issue-slot contents; anything not issued is a NOP bubble
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        w_stall  = 1'b0;
        w_issue  = 1'b0;
        opcode_d = OP_NOP;
        dest_d   = '0;
        src1_d   = '0;
        src2_d   = '0;
        mem_d    = '0;
        used1_d  = 1'b0;
        used2_d  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.instrValid) begin
                    if (w_hazard) begin
                        w_stall = 1'b1;
                        held_d  = bus.instr;
                        state_d = ST_STALL;
                    end else begin
                        w_issue = 1'b1;
                    end
                end
            end
            ST_STALL: begin
                w_issue = 1'b1;
                state_d = ST_RUN;
            end
            ST_HALT: begin
                w_stall = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (w_issue) begin
            opcode_d = w_dec_op;
            dest_d   = w_dec_dest;
            src1_d   = w_dec_src1;
            src2_d   = w_dec_src2;
            mem_d    = w_dec_mem;
            used1_d  = w_dec_used1;
            used2_d  = w_dec_used2;
            if (w_dec_op == OP_HLT) begin
                state_d = ST_HALT;
            end
        end
    end

    // Stage registers and FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            held_q   <= '0;
            opcode_q <= '0;
            dest_q   <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            mem_q    <= '0;
            used1_q  <= 1'b0;
            used2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            opcode_q <= opcode_d;
            dest_q   <= dest_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            mem_q    <= mem_d;
            used1_q  <= used1_d;
            used2_q  <= used2_d;
        end
    end

    assign bus.stall   = w_stall;
    assign bus.opcode  = opcode_q;
    assign bus.destReg = dest_q;
    assign bus.srcVal1 = src1_q;
    assign bus.srcVal2 = src2_q;
    assign bus.memAddr = mem_q;
    assign bus.used1   = used1_q;
    assign bus.used2   = used2_q;
    assign bus.halted  = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_decode_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_operand_fetch
//  Description : Self-checking bench for decode_operand_fetch: directed
//                vector table, random stimulus against a reference model,
//                and reset-during-stall sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_operand_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    decode_operand_fetch_if bus();

    decode_operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] instr;
        bit          valid;
        bit          we;
        logic [3:0]  wr;
        logic [15:0] wv;
        bit          st;
        logic [3:0]  op;
        logic [3:0]  dest;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [7:0]  mem;
        bit          u1;
        bit          u2;
        bit          h;
    } vec_t;

    vec_t tbl [18];

    // ---------------- reference model ----------------
    logic [15:0] m_rf [16];
    logic [3:0]  m_prev_op;
    logic [3:0]  m_prev_dest;
    bit          m_halted;
    bit          m_pending;
    logic [15:0] m_held;
    bit          m_stall;
    logic [50:0] m_out;

    function automatic bit reads1(input logic [3:0] op);
        return (op inside {[4'd2:4'd10], 4'd15});
    endfunction

    function automatic bit reads2(input logic [3:0] op);
        return (op inside {[4'd2:4'd8], 4'd10});
    endfunction

    function automatic logic [3:0] idx1_of(input logic [15:0] x);
        return (x[15:12] == 4'd15) ? x[11:8] : x[7:4];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_prev_op = '0; m_prev_dest = '0;
        m_halted = 0; m_pending = 0; m_held = '0;
    endtask

    task automatic model_step(input logic [15:0] instr, input bit valid, input bit we,
                              input logic [3:0] wr, input logic [15:0] wv);
        logic [15:0] x;
        logic [3:0]  op, e_op, e_dest;
        logic [15:0] s1, s2;
        logic [7:0]  e_mem;
        bit          issue, u1, u2;
        x = '0; issue = 0; m_stall = 0;
        e_op = '0; e_dest = '0; s1 = '0; s2 = '0; e_mem = '0; u1 = 0; u2 = 0;
        if (m_halted) begin
            m_stall = 1;
        end else if (m_pending) begin
            x = m_held; issue = 1; m_pending = 0;
        end else if (valid) begin
            op = instr[15:12];
            if (m_prev_op == 4'd14 &&
                ((reads1(op) && idx1_of(instr) == m_prev_dest) ||
                 (reads2(op) && instr[3:0] == m_prev_dest))) begin
                m_stall = 1; m_pending = 1; m_held = instr;
            end else begin
                x = instr; issue = 1;
            end
        end
        if (issue) begin
            op = x[15:12];
            if (op inside {[4'd11:4'd13]}) op = 4'd0;
            e_op   = op;
            e_dest = (op inside {[4'd2:4'd10], 4'd14}) ? x[11:8] : 4'd0;
            e_mem  = (op inside {4'd14, 4'd15}) ? x[7:0] : 8'd0;
            if (reads1(op)) begin
                s1 = (we && wr == idx1_of(x)) ? wv : m_rf[idx1_of(x)];
                u1 = (m_prev_op inside {[4'd2:4'd10]}) && idx1_of(x) == m_prev_dest;
            end
            if (reads2(op)) begin
                s2 = (we && wr == x[3:0]) ? wv : m_rf[x[3:0]];
                u2 = (m_prev_op inside {[4'd2:4'd10]}) && x[3:0] == m_prev_dest;
            end
            if (op == 4'd1) m_halted = 1;
        end
        m_prev_op = e_op;
        m_prev_dest = e_dest;
        if (we) m_rf[wr] = wv;
        m_out = {e_op, e_dest, s1, s2, e_mem, u1, u2, m_halted};
    endtask

    // ---------------- checking helpers ----------------
    function automatic logic [50:0] dut_out();
        return {bus.opcode, bus.destReg, bus.srcVal1, bus.srcVal2, bus.memAddr,
                bus.used1, bus.used2, bus.halted};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Entered at posedge+1; returns at the next posedge+1
    task automatic do_cycle(input logic [15:0] instr, input bit valid, input bit we,
                            input logic [3:0] wr, input logic [15:0] wv,
                            input bit use_exp, input bit xs, input logic [50:0] xo,
                            input string name);
        bit          es;
        logic [50:0] eo;
        bus.instr = instr; bus.instrValid = valid;
        bus.wbEn = we; bus.wbReg = wr; bus.wbVal = wv;
        model_step(instr, valid, we, wr, wv);
        es = use_exp ? xs : m_stall;
        eo = use_exp ? xo : m_out;
        #1;
        check({name, " stall"}, 64'(bus.stall), 64'(es));
        @(posedge clk); #1;
        check({name, " out"}, 64'(dut_out()), 64'(eo));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [15:0] ri;
    bit          rv;
    logic [3:0]  rop;

    initial begin
        bus.instr = '0; bus.instrValid = 0; bus.wbEn = 0; bus.wbReg = '0; bus.wbVal = '0;
        model_reset();
        #1;
        check("reset outputs", 64'(dut_out()), 64'd0);
        check("reset stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //                instr    v  we wr    wv        st op    dest  s1        s2       mem    u1 u2 h
        tbl[0]  = '{16'h0000, 0, 1, 4'd1, 16'd5,    0, 4'd0, 4'd0, 16'd0,    16'd0,   8'h00, 0, 0, 0};
        tbl[1]  = '{16'h0000, 0, 1, 4'd2, 16'd7,    0, 4'd0, 4'd0, 16'd0,    16'd0,   8'h00, 0, 0, 0};
        tbl[2]  = '{16'h2312, 1, 0, 4'd0, 16'd0,    0, 4'd2, 4'd3, 16'd5,    16'd7,   8'h00, 0, 0, 0};
        tbl[3]  = '{16'h3431, 1, 0, 4'd0, 16'd0,    0, 4'd3, 4'd4, 16'd0,    16'd5,   8'h00, 1, 0, 0};
        tbl[4]  = '{16'hE520, 1, 0, 4'd0, 16'd0,    0, 4'd14,4'd5, 16'd0,    16'd0,   8'h20, 0, 0, 0};
        tbl[5]  = '{16'h2655, 1, 0, 4'd0, 16'd0,    1, 4'd0, 4'd0, 16'd0,    16'd0,   8'h00, 0, 0, 0};
        tbl[6]  = '{16'h2655, 1, 1, 4'd5, 16'h1234, 0, 4'd2, 4'd6, 16'h1234, 16'h1234,8'h00, 0, 0, 0};
        tbl[7]  = '{16'hF240, 1, 0, 4'd0, 16'd0,    0, 4'd15,4'd0, 16'd7,    16'd0,   8'h40, 0, 0, 0};
        tbl[8]  = '{16'h2716, 1, 0, 4'd0, 16'd0,    0, 4'd2, 4'd7, 16'd5,    16'd0,   8'h00, 0, 0, 0};
        tbl[9]  = '{16'hA827, 1, 0, 4'd0, 16'd0,    0, 4'd10,4'd8, 16'd7,    16'd0,   8'h00, 0, 1, 0};
        tbl[10] = '{16'h9988, 1, 0, 4'd0, 16'd0,    0, 4'd9, 4'd9, 16'd0,    16'd0,   8'h00, 1, 0, 0};
        tbl[11] = '{16'hC123, 1, 0, 4'd0, 16'd0,    0, 4'd0, 4'd0, 16'd0,    16'd0,   8'h00, 0, 0, 0};
        tbl[12] = '{16'hE210, 1, 0, 4'd0, 16'd0,    0, 4'd14,4'd2, 16'd0,    16'd0,   8'h10, 0, 0, 0};
        tbl[13] = '{16'hF244, 1, 0, 4'd0, 16'd0,    1, 4'd0, 4'd0, 16'd0,    16'd0,   8'h00, 0, 0, 0};
        tbl[14] = '{16'hF244, 1, 1, 4'd2, 16'h00AB, 0, 4'd15,4'd0, 16'h00AB, 16'd0,   8'h44, 0, 0, 0};
        tbl[15] = '{16'h1000, 1, 0, 4'd0, 16'd0,    0, 4'd1, 4'd0, 16'd0,    16'd0,   8'h00, 0, 0, 1};
        tbl[16] = '{16'h2312, 1, 1, 4'd3, 16'h0055, 1, 4'd0, 4'd0, 16'd0,    16'd0,   8'h00, 0, 0, 1};
        tbl[17] = '{16'h2312, 1, 0, 4'd0, 16'd0,    1, 4'd0, 4'd0, 16'd0,    16'd0,   8'h00, 0, 0, 1};

        for (int i = 0; i < 18; i++) begin
            do_cycle(tbl[i].instr, tbl[i].valid, tbl[i].we, tbl[i].wr, tbl[i].wv, 1, tbl[i].st,
                     {tbl[i].op, tbl[i].dest, tbl[i].s1, tbl[i].s2, tbl[i].mem,
                      tbl[i].u1, tbl[i].u2, tbl[i].h},
                     $sformatf("vec%0d", i));
        end

        // Random traffic against the reference model; HLT kept for the end
        do_reset();
        ri = '0;
        for (int n = 0; n < 600; n++) begin
            if (!m_pending) begin
                rop = 4'($urandom_range(0, 15));
                if (rop == 4'd1) rop = 4'd2;
                ri = {rop, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3))};
                rv = ($urandom_range(0, 9) != 0);
            end else begin
                rv = 1;
            end
            do_cycle(ri, rv, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                     16'($urandom), 0, 0, '0, "rand");
        end
        do_cycle(16'h0000, 0, 0, 4'd0, 16'd0, 0, 0, '0, "pre-hlt");
        do_cycle(16'h1000, 1, 0, 4'd0, 16'd0, 0, 0, '0, "hlt");
        for (int n = 0; n < 3; n++) begin
            do_cycle(16'h2312, 1, 1, 4'd1, 16'($urandom), 0, 0, '0, "halted");
        end

        // Asynchronous reset while outputs hold a real instruction
        do_reset();
        do_cycle(16'h0000, 0, 1, 4'd1, 16'd9, 0, 0, '0, "wr r1");
        do_cycle(16'h2311, 1, 0, 4'd0, 16'd0, 0, 0, '0, "add r1");
        rst = 1'b1;
        model_reset();
        #1;
        check("async rst out", 64'(dut_out()), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset in the STALL cycle discards the held instruction
        do_cycle(16'h0000, 0, 1, 4'd5, 16'h0033, 0, 0, '0, "wr r5");
        do_cycle(16'hE520, 1, 0, 4'd0, 16'd0, 0, 0, '0, "load r5");
        do_cycle(16'h2655, 1, 0, 4'd0, 16'd0, 0, 1, '0, "load-use");
        rst = 1'b1;
        model_reset();
        #1;
        check("stall rst out", 64'(dut_out()), 64'd0);
        check("stall rst stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_cycle(16'h2655, 0, 0, 4'd0, 16'd0, 1, 0, '0, "no held issue");
        do_cycle(16'h2315, 1, 0, 4'd0, 16'd0, 1, 0,
                 {4'd2, 4'd3, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0}, "rf cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
